// File: rtl/nf_cc_pkg.sv
// rtl/nf_cc_pkg.sv - shared types and limits for the nf_cc cross-connect
package nf_cc_pkg;

  typedef enum logic {CC_IDLE, CC_BUSY} cc_state_t;

  parameter int CC_MST_MAX = 8;

endpackage

// File: rtl/nf_cc_pick.sv
// rtl/nf_cc_pick.sv - combinational winner selector, fixed priority or round-robin
module nf_cc_pick
  import nf_cc_pkg::*;
#(
  parameter int MST_N = 2,
  parameter int IW    = (MST_N > 1) ? $clog2(MST_N) : 1
) (
  input  logic [MST_N-1:0] req,
  input  logic [IW-1:0]    last,
  input  logic             mode,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  logic [IW-1:0] sel;

  always_comb begin
    idx   = '0;
    sel   = '0;
    valid = |req;
    if (!mode) begin
      for (int i = 0; i < MST_N; i++) begin
        if (req[i]) idx = IW'(i);
      end
    end else begin
      // Scan from farthest to nearest so the nearest candidate after last wins.
      for (int k = MST_N; k >= 1; k--) begin
        sel = IW'((int'(last) + k) % MST_N);
        if (req[sel]) idx = sel;
      end
    end
  end

endmodule

// File: rtl/nf_cc_arb.sv
// rtl/nf_cc_arb.sv - N-master to 1-slave cross-connect with registered grant and ack timeout
module nf_cc_arb
  import nf_cc_pkg::*;
#(
  parameter int MST_N   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_MODE = 0,
  parameter int TMO_W   = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [MST_N*ADDR_W-1:0]   addr_m,
  input  logic [MST_N*DATA_W-1:0]   wd_m,
  input  logic [MST_N-1:0]          we_m,
  input  logic [MST_N-1:0]          req_m,
  output logic [MST_N*DATA_W-1:0]   rd_m,
  output logic [MST_N-1:0]          req_ack_m,
  output logic [ADDR_W-1:0]         addr_s,
  output logic [DATA_W-1:0]         wd_s,
  output logic                      we_s,
  output logic                      req_s,
  input  logic [DATA_W-1:0]         rd_s,
  input  logic                      req_ack_s,
  output logic                      err_tmo,
  output logic [$clog2(MST_N)-1:0]  owner
);

  localparam int IW = $clog2(MST_N);
  localparam int TW = (TMO_W > 0) ? TMO_W : 1;
  localparam logic [TW-1:0] TMO_MAX = '1;

  cc_state_t     state;
  logic [IW-1:0] last;
  logic [TW-1:0] tmo_cnt;
  logic [IW-1:0] win_idx;
  logic          win_vld;
  logic          busy;
  logic          own_req;
  logic          tmo_hit;

  nf_cc_pick #(
    .MST_N (MST_N),
    .IW    (IW)
  ) u_pick (
    .req   (req_m),
    .last  (last),
    .mode  (RR_MODE != 0),
    .idx   (win_idx),
    .valid (win_vld)
  );

  assign busy    = (state == CC_BUSY);
  assign own_req = req_m[owner];
  assign tmo_hit = (TMO_W > 0) && (tmo_cnt == TMO_MAX);
  // An ack in the terminal cycle takes precedence, and a withdrawn request is an abort, not a timeout.
  assign err_tmo = busy && own_req && !req_ack_s && tmo_hit;

  always_comb begin
    req_s     = 1'b0;
    addr_s    = '0;
    wd_s      = '0;
    we_s      = 1'b0;
    req_ack_m = '0;
    rd_m      = '0;
    if (busy) begin
      req_s                         = own_req;
      addr_s                        = addr_m[owner*ADDR_W +: ADDR_W];
      wd_s                          = wd_m[owner*DATA_W +: DATA_W];
      we_s                          = we_m[owner];
      req_ack_m[owner]              = req_ack_s;
      rd_m[owner*DATA_W +: DATA_W]  = rd_s;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= CC_IDLE;
      owner   <= '0;
      last    <= IW'(MST_N - 1);
      tmo_cnt <= '0;
    end else begin
      case (state)
        CC_IDLE: begin
          tmo_cnt <= '0;
          if (win_vld) begin
            owner <= win_idx;
            state <= CC_BUSY;
          end
        end
        CC_BUSY: begin
          if (!tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
          if (req_ack_s) begin
            last  <= owner;
            state <= CC_IDLE;
          end else if (!own_req) begin
            state <= CC_IDLE;
          end else if (err_tmo) begin
            last  <= owner;
            state <= CC_IDLE;
          end
        end
        default: state <= CC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nf_cc_arb.sv
// tb/tb_nf_cc_arb.sv - randomized and directed check of two nf_cc_arb configurations
module tb_nf_cc_arb;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         resetn;
  logic [127:0] addr_m, wd_m;
  logic [3:0]   we_m, req_m;
  logic [31:0]  rd_s;
  logic         req_ack_s;

  logic [127:0] rd_m_o [2];
  logic [3:0]   req_ack_m_o [2];
  logic [31:0]  addr_s_o [2], wd_s_o [2];
  logic         we_s_o [2], req_s_o [2], err_o [2];
  logic [1:0]   owner_o [2];

  int n_vec = 0;
  int n_err = 0;

  bit mb [2];
  int mo [2], ml [2], mc [2];

  always #5 clk = ~clk;

  nf_cc_arb #(.MST_N(4), .ADDR_W(32), .DATA_W(32), .RR_MODE(1), .TMO_W(3)) u_rr (
    .clk(clk), .resetn(resetn), .addr_m(addr_m), .wd_m(wd_m), .we_m(we_m), .req_m(req_m),
    .rd_m(rd_m_o[0]), .req_ack_m(req_ack_m_o[0]), .addr_s(addr_s_o[0]), .wd_s(wd_s_o[0]),
    .we_s(we_s_o[0]), .req_s(req_s_o[0]), .rd_s(rd_s), .req_ack_s(req_ack_s),
    .err_tmo(err_o[0]), .owner(owner_o[0])
  );

  nf_cc_arb #(.MST_N(4), .ADDR_W(32), .DATA_W(32), .RR_MODE(0), .TMO_W(0)) u_fp (
    .clk(clk), .resetn(resetn), .addr_m(addr_m), .wd_m(wd_m), .we_m(we_m), .req_m(req_m),
    .rd_m(rd_m_o[1]), .req_ack_m(req_ack_m_o[1]), .addr_s(addr_s_o[1]), .wd_s(wd_s_o[1]),
    .we_s(we_s_o[1]), .req_s(req_s_o[1]), .rd_s(rd_s), .req_ack_s(req_ack_s),
    .err_tmo(err_o[1]), .owner(owner_o[1])
  );

  task automatic chk(input string nm, input int d, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, d, $time, act, exp);
    end
  endtask

  // Model: dut 0 is round-robin with an 8-cycle timeout, dut 1 is highest-index priority without timeout.
  function automatic int winner(int d);
    if (d == 1) begin
      for (int i = N - 1; i >= 0; i--) if (req_m[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (req_m[(ml[d] + k) % N]) return (ml[d] + k) % N;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mb[d] = 1'b0; mo[d] = 0; ml[d] = N - 1; mc[d] = 0;
    end
  endtask

  task automatic settle();
    bit b;
    int o;
    #4;
    for (int d = 0; d < 2; d++) begin
      b = mb[d];
      o = mo[d];
      chk("req_s", d, req_s_o[d], b ? req_m[o] : 1'b0);
      chk("addr_s", d, addr_s_o[d], b ? addr_m[o*32 +: 32] : 32'h0);
      chk("wd_s", d, wd_s_o[d], b ? wd_m[o*32 +: 32] : 32'h0);
      chk("we_s", d, we_s_o[d], b ? we_m[o] : 1'b0);
      chk("req_ack_m", d, req_ack_m_o[d], (b && req_ack_s) ? (4'b0001 << o) : 4'b0000);
      chk("rd_m", d, rd_m_o[d], b ? (128'(rd_s) << (32 * o)) : 128'h0);
      chk("err_tmo", d, err_o[d], b && d == 0 && mc[d] == 7 && !req_ack_s && req_m[o]);
      chk("owner", d, owner_o[d], o);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!resetn) model_reset();
    else begin
      for (int d = 0; d < 2; d++) begin
        if (!mb[d]) begin
          if (req_m != 4'b0000) begin
            mo[d] = winner(d); mb[d] = 1'b1; mc[d] = 0;
          end
        end else if (req_ack_s) begin
          ml[d] = mo[d]; mb[d] = 1'b0;
        end else if (!req_m[mo[d]]) begin
          mb[d] = 1'b0;
        end else if (d == 0 && mc[d] == 7) begin
          ml[d] = mo[d]; mb[d] = 1'b0;
        end else begin
          mc[d]++;
        end
      end
    end
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic quiesce();
    req_m = 4'b0000;
    req_ack_s = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    int pct;
    resetn = 1'b0; req_m = '0; we_m = '0; rd_s = '0; req_ack_s = 1'b0;
    addr_m = {$urandom, $urandom, $urandom, $urandom};
    wd_m   = {$urandom, $urandom, $urandom, $urandom};
    model_reset();
    @(posedge clk); #1;
    step();
    resetn = 1'b1;

    // Single master 2 read: one-cycle request latency, data routed only to master 2.
    addr_m[2*32 +: 32] = 32'h100;
    we_m = 4'b0000;
    rd_s = 32'hDEADBEEF;
    req_m = 4'b0100;
    settle();
    chk("lat_req_s_idle", 0, req_s_o[0], 1'b0);
    tick();
    req_ack_s = 1'b1;
    settle();
    chk("addr_0x100", 0, addr_s_o[0], 32'h100);
    chk("ack_m2", 0, req_ack_m_o[0], 4'b0100);
    chk("rd_m2_only", 0, rd_m_o[0], {32'h0, 32'hDEADBEEF, 64'h0});
    tick();
    quiesce();

    // Reset mid-transfer drops req_s and acks at once; round-robin restarts at master 0.
    req_m = 4'b0010;
    step();
    req_ack_s = 1'b1;
    #2;
    chk("pre_rst_ack", 0, req_ack_m_o[0], 4'b0010);
    resetn = 1'b0;
    #1;
    chk("rst_req_s", 0, req_s_o[0], 1'b0);
    chk("rst_ack_m", 0, req_ack_m_o[0], 4'b0000);
    chk("rst_req_s", 1, req_s_o[1], 1'b0);
    model_reset();
    req_ack_s = 1'b0;
    @(posedge clk); #1;
    settle();
    chk("rst_owner", 0, owner_o[0], 2'd0);
    req_m = 4'b1111;
    req_ack_s = 1'b1;
    resetn = 1'b1;
    tick();
    for (int c = 0; c < 10; c++) begin
      settle();
      chk("rr_bubble", 0, req_s_o[0], (c % 2) == 0);
      if ((c % 2) == 0) chk("rr_order", 0, owner_o[0], (c / 2) % 4);
      tick();
    end
    quiesce();

    // Fixed priority: master 1 beats master 0 every time.
    req_m = 4'b0011;
    req_ack_s = 1'b1;
    for (int c = 0; c < 8; c++) begin
      settle();
      chk("fp_ack", 1, req_ack_m_o[1], (c % 2) ? 4'b0010 : 4'b0000);
      tick();
    end
    quiesce();

    // Timeout: err_tmo in BUSY cycle 8, one IDLE cycle, then re-granted.
    req_m = 4'b0001;
    req_ack_s = 1'b0;
    for (int c = 0; c < 11; c++) begin
      settle();
      chk("tmo_err", 0, err_o[0], c == 8);
      chk("tmo_req_s", 0, req_s_o[0], (c >= 1 && c <= 8) || c == 10);
      tick();
    end
    quiesce();

    // Owner withdraws mid-BUSY: abort without ack, next requester granted after IDLE.
    req_m = 4'b1001;
    step();
    settle();
    chk("abort_owner", 0, owner_o[0], 2'd3);
    tick();
    req_m = 4'b0001;
    settle();
    chk("abort_req_s", 0, req_s_o[0], 1'b0);
    chk("abort_ack", 0, req_ack_m_o[0], 4'b0000);
    tick();
    step();
    settle();
    chk("abort_next", 0, owner_o[0], 2'd0);
    chk("abort_next_req", 0, req_s_o[0], 1'b1);
    tick();
    quiesce();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      pct = ((cyc / 500) % 2) ? 8 : 40;
      for (int i = 0; i < N; i++) if ($urandom_range(5) == 0) req_m[i] = ~req_m[i];
      addr_m = {$urandom, $urandom, $urandom, $urandom};
      wd_m   = {$urandom, $urandom, $urandom, $urandom};
      we_m   = 4'($urandom);
      rd_s   = $urandom;
      req_ack_s = ($urandom_range(99) < pct);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
